// File: rtl/packetmem_pkg.sv
// Shared definitions for the packet-buffer rotation scheduler.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package packetmem_pkg;

   localparam int SEL_WIDTH = 2;

   typedef logic [SEL_WIDTH-1:0] buf_id_t;

   localparam buf_id_t BUF_NONE = 2'b00;
   localparam buf_id_t BUF_PING = 2'b01;
   localparam buf_id_t BUF_PANG = 2'b10;
   localparam buf_id_t BUF_PUNG = 2'b11;

   // Lifecycle of one buffer: filled, queued for CPU, filtered, queued for forwarder, drained
   typedef enum logic [2:0] {
      ST_FREE,
      ST_SN,
      ST_READY,
      ST_CPU,
      ST_ACC,
      ST_FWD
   } buf_state_e;

endpackage

// File: rtl/bufid_fifo.sv
// Depth-3 FIFO of buffer IDs; head and empty flag come straight from registers.
// Latency: a push is visible at the head one edge later; push and pop may share a cycle.
// Backpressure: pop on empty is ignored; push when full without a pop is dropped (cannot occur with 3 buffers).
module bufid_fifo
   import packetmem_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_vld,
   input  buf_id_t push_dat,
   input  logic    pop_rdy,
   output buf_id_t head_dat,
   output logic    empty
);

   localparam logic [1:0] DEPTH = 2'd3;

   buf_id_t    mem_q [DEPTH];
   buf_id_t    mem_d [DEPTH];
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push, do_pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == DEPTH - 2'd1) ? 2'd0 : p + 2'd1;
   endfunction

   // Next-state: pop the prior head, append at the tail, count tracks occupancy
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      do_pop   = pop_rdy && (cnt_q != 2'd0);
      do_push  = push_vld && ((cnt_q != DEPTH) || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   // Storage and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) mem_q[i] <= BUF_NONE;
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign empty    = (cnt_q == 2'd0);

endmodule

// File: rtl/packetmem_sched.sv
// Rotates ping/pang/pung through snooper -> CPU -> forwarder (or back to free on reject).
// Latency: new grant one edge after a done pulse; queued or freed IDs usable one edge later.
// Backpressure: an agent with nothing eligible idles at sel=00/rdy=0 until a buffer reaches it.
module packetmem_sched
   import packetmem_pkg::*;
#(
   parameter int NBUF = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sn_done,
   input  logic                 cpu_done,
   input  logic                 cpu_acc,
   input  logic                 fwd_done,
   output logic [SEL_WIDTH-1:0] sn_sel,
   output logic [SEL_WIDTH-1:0] cpu_sel,
   output logic [SEL_WIDTH-1:0] fwd_sel,
   output logic                 sn_rdy,
   output logic                 cpu_rdy,
   output logic                 fwd_rdy,
   output logic                 proto_err
);

   // The 2-bit select only has codes for three buffers
   if (NBUF != 3) begin : g_nbuf_check
      $error("packetmem_sched: NBUF must be 3");
   end

   buf_state_e st_q [1:NBUF];
   buf_state_e st_d [1:NBUF];
   buf_id_t    sn_sel_q, sn_sel_d, cpu_sel_q, cpu_sel_d, fwd_sel_q, fwd_sel_d;
   logic       sn_rdy_q, cpu_rdy_q, fwd_rdy_q;
   logic       proto_err_q, proto_err_d;
   buf_id_t    free_id;
   logic       rdy_push, rdy_pop, rdy_empty;
   logic       acc_push, acc_pop, acc_empty;
   buf_id_t    rdy_head, acc_head;

   bufid_fifo u_ready_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (rdy_push),
      .push_dat (sn_sel_q),
      .pop_rdy  (rdy_pop),
      .head_dat (rdy_head),
      .empty    (rdy_empty)
   );

   bufid_fifo u_acc_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (acc_push),
      .push_dat (cpu_sel_q),
      .pop_rdy  (acc_pop),
      .head_dat (acc_head),
      .empty    (acc_empty)
   );

   // Retire finished buffers and grant the next one to each agent, all from start-of-cycle state
   always_comb begin
      st_d        = st_q;
      sn_sel_d    = sn_sel_q;
      cpu_sel_d   = cpu_sel_q;
      fwd_sel_d   = fwd_sel_q;
      proto_err_d = proto_err_q;
      rdy_push    = 1'b0;
      rdy_pop     = 1'b0;
      acc_push    = 1'b0;
      acc_pop     = 1'b0;

      free_id = BUF_NONE;
      for (int b = NBUF; b >= 1; b--) begin
         if (st_q[b] == ST_FREE) free_id = b[SEL_WIDTH-1:0];
      end

      // Snooper: finished buffer joins the CPU queue, lowest free buffer is handed out
      if (sn_done) begin
         if (sn_sel_q == BUF_NONE) begin
            proto_err_d = 1'b1;
         end else begin
            st_d[sn_sel_q] = ST_READY;
            rdy_push       = 1'b1;
         end
      end
      if ((sn_sel_q == BUF_NONE) || sn_done) begin
         sn_sel_d = free_id;
         if (free_id != BUF_NONE) st_d[free_id] = ST_SN;
      end

      // CPU: accepted buffer joins the forward queue, rejected one is freed
      if (cpu_done) begin
         if (cpu_sel_q == BUF_NONE) begin
            proto_err_d = 1'b1;
         end else if (cpu_acc) begin
            st_d[cpu_sel_q] = ST_ACC;
            acc_push        = 1'b1;
         end else begin
            st_d[cpu_sel_q] = ST_FREE;
         end
      end
      if ((cpu_sel_q == BUF_NONE) || cpu_done) begin
         rdy_pop   = !rdy_empty;
         cpu_sel_d = rdy_empty ? BUF_NONE : rdy_head;
         if (!rdy_empty) st_d[rdy_head] = ST_CPU;
      end

      // Forwarder: drained buffer is freed, next accepted buffer is taken in order
      if (fwd_done) begin
         if (fwd_sel_q == BUF_NONE) begin
            proto_err_d = 1'b1;
         end else begin
            st_d[fwd_sel_q] = ST_FREE;
         end
      end
      if ((fwd_sel_q == BUF_NONE) || fwd_done) begin
         acc_pop   = !acc_empty;
         fwd_sel_d = acc_empty ? BUF_NONE : acc_head;
         if (!acc_empty) st_d[acc_head] = ST_FWD;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 1; b <= NBUF; b++) st_q[b] <= ST_FREE;
         sn_sel_q    <= BUF_NONE;
         cpu_sel_q   <= BUF_NONE;
         fwd_sel_q   <= BUF_NONE;
         sn_rdy_q    <= 1'b0;
         cpu_rdy_q   <= 1'b0;
         fwd_rdy_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         sn_sel_q    <= sn_sel_d;
         cpu_sel_q   <= cpu_sel_d;
         fwd_sel_q   <= fwd_sel_d;
         sn_rdy_q    <= (sn_sel_d != BUF_NONE);
         cpu_rdy_q   <= (cpu_sel_d != BUF_NONE);
         fwd_rdy_q   <= (fwd_sel_d != BUF_NONE);
         proto_err_q <= proto_err_d;
      end
   end

   assign sn_sel    = sn_sel_q;
   assign cpu_sel   = cpu_sel_q;
   assign fwd_sel   = fwd_sel_q;
   assign sn_rdy    = sn_rdy_q;
   assign cpu_rdy   = cpu_rdy_q;
   assign fwd_rdy   = fwd_rdy_q;
   assign proto_err = proto_err_q;

endmodule
